// File: rtl/mips_data_mem_responder.sv
// mips_data_mem_responder
//
// Responder side of the core's data-memory port. It accepts one word request
// at a time, stays busy for LATENCY cycles, then reports completion with a
// single-cycle mem_done pulse. Storage is byte addressed and big-endian:
// lane 0 is the byte at the request address and is the MSB of the word.
//
// Optional build feature (macro MEM_ALIGN_CHECK_EN):
//   defined   - an address with addr[1:0] != 0 is illegal. A read returns
//               zero, a write is dropped, and mem_err is raised with mem_done.
//   undefined - addr[1:0] is ignored, so the access is aligned down to a word.
//
// Parameters
//   ADDR_BITS  storage size is 2**ADDR_BITS bytes (must be at least 3)
//   LATENCY    cycles spent in BUSY per access, 1..15
//   BASE_ADDR  first byte address mapped to storage
//
// Ports
//   clk           clock; all state updates happen on the rising edge
//   rst_b         asynchronous active-low reset (storage is not cleared)
//   mem_req       request valid from the core
//   mem_ready     responder can accept; a transfer occurs on mem_req && mem_ready
//   mem_addr      byte address of the word
//   mem_write_en  1 = write, 0 = read; sampled with the request
//   mem_data_in   write lanes [0:3]; lane 0 = MSB = byte at addr
//   mem_data_out  read lanes [0:3]; held until the next completed read
//   mem_done      one-cycle pulse: access complete, read data valid
//   mem_err       valid with mem_done: the access was illegal
//   halted        core halted; new requests are refused while IDLE
module mips_data_mem_responder #(
  parameter int          ADDR_BITS = 16,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            mem_req,
  output logic            mem_ready,
  input  logic [31:0]     mem_addr,
  input  logic            mem_write_en,
  input  logic [0:3][7:0] mem_data_in,
  output logic [0:3][7:0] mem_data_out,
  output logic            mem_done,
  output logic            mem_err,
  input  logic            halted
);

  localparam int ROW_BITS = ADDR_BITS - 2;
  localparam int DEPTH    = 1 << ROW_BITS;
  // Highest offset at which a full word still fits in storage.
  localparam logic [32:0] LAST_OFF = (33'd1 << ADDR_BITS) - 33'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      count_reg, count_next;
  logic            err_reg, err_next;
  logic            out_zero_reg, out_zero_next;
  logic [1:0]      rot_reg, rot_next;

  // Request captured at acceptance.
  logic [31:2]     addr_reg;
  logic            write_en_reg;
  logic [0:3][7:0] data_reg;

  logic            accept;
  logic            access;
  logic [31:0]     off;
  logic            out_of_range;
  logic            illegal;
  logic            wr_en;
  logic            rd_en;
  logic [7:0]      bank_rd [0:3];

  // Alignment handling
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_reg;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      misalign_reg <= 1'b0;
    end else if (accept) begin
      misalign_reg <= (mem_addr[1:0] != 2'b00);
    end
  end

  assign illegal = out_of_range | misalign_reg;
`else
  // The low address bits are intentionally discarded in this build.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^mem_addr[1:0];

  assign illegal = out_of_range;
`endif

  // Offset and range check
  // The offset is computed from the word-aligned address and wraps in 32 bits,
  // so an address below BASE_ADDR becomes a huge offset and fails the range check.
  assign off          = {addr_reg, 2'b00} - BASE_ADDR;
  assign out_of_range = ({1'b0, off} > LAST_OFF);

  assign accept = mem_req && mem_ready;
  assign access = (state_reg == BUSY) && (count_reg == 4'd0);
  assign wr_en  = access && write_en_reg && !illegal;
  assign rd_en  = access && !write_en_reg && !illegal;

  // State and capture registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg    <= IDLE;
      count_reg    <= 4'd0;
      err_reg      <= 1'b0;
      out_zero_reg <= 1'b1;
      rot_reg      <= 2'd0;
      addr_reg     <= '0;
      write_en_reg <= 1'b0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      err_reg      <= err_next;
      out_zero_reg <= out_zero_next;
      rot_reg      <= rot_next;
      if (accept) begin
        addr_reg     <= mem_addr[31:2];
        write_en_reg <= mem_write_en;
        data_reg     <= mem_data_in;
      end
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    err_next      = err_reg;
    out_zero_next = out_zero_reg;
    rot_next      = rot_reg;
    mem_ready     = 1'b0;
    mem_done      = 1'b0;
    mem_err       = 1'b0;

    case (state_reg)
      IDLE: begin
        mem_ready = !halted;
        if (mem_req && !halted) begin
          count_next = 4'(LATENCY - 1);
          state_next = BUSY;
        end
      end

      BUSY: begin
        if (count_reg == 4'd0) begin
          // The storage access happens on this edge.
          err_next = illegal;
          if (!write_en_reg) begin
            // Only reads update the visible read data; writes leave it alone.
            out_zero_next = illegal;
            rot_next      = off[1:0];
          end
          state_next = RESP;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end

      RESP: begin
        mem_done   = 1'b1;
        mem_err    = err_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Storage: four byte-wide banks
  // Byte address b lives in bank b%4 at row b/4. Lane i of an access targets
  // byte off+i, so bank gi serves lane (gi - off) mod 4. This keeps each bank a
  // plain single-port RAM with a registered read even if BASE_ADDR is not
  // word aligned.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0]          ram [0:DEPTH-1];
      logic [7:0]          rd_reg;
      logic [1:0]          lane;
      logic [ROW_BITS-1:0] row;

      assign lane = 2'(gi) - off[1:0];
      assign row  = ROW_BITS'((off + {30'd0, lane}) >> 2);

      always_ff @(posedge clk) begin
        if (wr_en) begin
          ram[row] <= data_reg[lane];
        end
        if (rd_en) begin
          rd_reg <= ram[row];
        end
      end

      assign bank_rd[gi] = rd_reg;
    end
  endgenerate

  // Read lanes
  // The bank registers and the rotation/zero flags update on the same edge, so
  // the output is a stable function of the last completed read.
  always_comb begin
    mem_data_out = '0;
    for (int i = 0; i < 4; i++) begin
      mem_data_out[i] = out_zero_reg ? 8'h00 : bank_rd[rot_reg + 2'(i)];
    end
  end

endmodule

// File: tb/tb_mips_data_mem_responder.sv
module tb_mips_data_mem_responder;

  localparam int          LAT       = 2;
  localparam int          ABITS     = 16;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int unsigned MEM_BYTES = 1 << ABITS;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            mem_req;
  logic            mem_ready;
  logic [31:0]     mem_addr;
  logic            mem_write_en;
  logic [0:3][7:0] mem_data_in;
  logic [0:3][7:0] mem_data_out;
  logic            mem_done;
  logic            mem_err;
  logic            halted;

  // Second instance with LATENCY=1 for the handshake stress case.
  logic            s_req;
  logic            s_ready;
  logic [31:0]     s_addr;
  logic            s_we;
  logic [0:3][7:0] s_data_in;
  logic [0:3][7:0] s_data_out;
  logic            s_done;
  logic            s_err;
  logic            s_halted;

  always #5 clk = ~clk;

  mips_data_mem_responder #(.ADDR_BITS(ABITS), .LATENCY(LAT), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_err(mem_err),
    .halted(halted)
  );

  mips_data_mem_responder #(.ADDR_BITS(ABITS), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .mem_req(s_req), .mem_ready(s_ready),
    .mem_addr(s_addr), .mem_write_en(s_we), .mem_data_in(s_data_in),
    .mem_data_out(s_data_out), .mem_done(s_done), .mem_err(s_err),
    .halted(s_halted)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a sparse byte memory plus the last visible read word.
  logic [7:0]  mdl [logic [31:0]];
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  function automatic void model_access(input logic [31:0] addr, input logic we,
                                       input logic [31:0] wdata, output exp_t e);
    logic [31:0] word_addr;
    logic [31:0] off;
    logic        bad;
    logic [31:0] rd;
    logic        known;
    word_addr = addr & 32'hFFFF_FFFC;
    off       = word_addr - BASE;
    bad       = (off > MEM_BYTES - 4);
`ifdef MEM_ALIGN_CHECK_EN
    if (addr % 4 != 0) bad = 1'b1;
`endif
    known = 1'b1;
    if (we) begin
      if (!bad) begin
        for (int i = 0; i < 4; i++) mdl[off + i] = wdata[31 - 8*i -: 8];
      end
      e.data = last_rd;
    end else begin
      rd = 32'h0;
      if (!bad) begin
        for (int i = 0; i < 4; i++) begin
          if (mdl.exists(off + i)) rd[31 - 8*i -: 8] = mdl[off + i];
          else known = 1'b0;
        end
      end
      last_rd = rd;
      e.data  = rd;
    end
    e.err = bad;
    e.chk = known;
  endfunction

  // Monitor: pops one expectation per mem_done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b && mem_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: got mem_done=1 at cycle %0d, expected no response", cyc);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_err"}, {31'd0, mem_err}, {31'd0, e.err});
        if (e.chk) check({e.name, "_data"}, mem_data_out, e.data);
        check({e.name, "_latency"}, cyc, e.due);
        $display("txn %s: data=%h err=%0d cycle=%0d", e.name, mem_data_out, mem_err, cyc);
      end
    end
  end

  task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input string name, input bit halt_mid);
    int   waited;
    exp_t e;
    @(negedge clk);
    mem_req      = 1'b1;
    mem_addr     = addr;
    mem_write_en = we;
    mem_data_in  = wdata;
    waited = 0;
    while (!mem_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!mem_ready) begin
      check({name, "_accept_timeout"}, {31'd0, mem_ready}, 32'd1);
      mem_req = 1'b0;
    end else begin
      model_access(addr, we, wdata, e);
      e.due  = cyc + LAT + 1;
      e.name = name;
      exp_q.push_back(e);
      @(negedge clk);
      mem_req = 1'b0;
      if (halt_mid) halted = 1'b1;
      waited = 0;
      while (exp_q.size() != 0 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (exp_q.size() != 0) begin
        check({name, "_done_timeout"}, exp_q.size(), 32'd0);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish by 500000");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned pool [12];
    int          cnt;
    int          kind;
    logic [31:0] a;

    rst_b = 1'b0; halted = 1'b0; mem_req = 1'b0; mem_addr = '0;
    mem_write_en = 1'b0; mem_data_in = '0;
    s_req = 1'b0; s_addr = '0; s_we = 1'b0; s_data_in = '0; s_halted = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_done",  {31'd0, mem_done},  32'd0);
    check("rst_err",   {31'd0, mem_err},   32'd0);
    check("rst_data",  mem_data_out,       32'd0);
    rst_b = 1'b1;

    // Directed: write/read, byte order, misalignment, range
    do_access(32'h14, 1'b1, 32'h1122_3344, "wr14", 1'b0);
    do_access(32'h10, 1'b1, 32'hDEAD_BEEF, "wr10", 1'b0);
    do_access(32'h10, 1'b0, 32'h0,         "rd10", 1'b0);
    do_access(32'h14, 1'b0, 32'h0,         "rd14", 1'b0);
    do_access(32'h12, 1'b0, 32'h0,         "rd12_misaligned", 1'b0);
    do_access(32'h0,  1'b1, 32'h0102_0304, "wr0", 1'b0);
    do_access(32'hFFFC, 1'b1, 32'hA1B2_C3D4, "wrFFFC", 1'b0);
    do_access(32'h0001_0000, 1'b0, 32'h0,  "rd_oor", 1'b0);
    do_access(32'h0001_0000, 1'b1, 32'h5A5A_5A5A, "wr_oor", 1'b0);
    do_access(32'hFFFC, 1'b0, 32'h0,       "rdFFFC", 1'b0);
    do_access(32'h0,  1'b0, 32'h0,         "rd0_after_oor", 1'b0);

    // Halt rising mid-access, then refusal while halted
    do_access(32'h10, 1'b0, 32'h0, "rd10_halt_mid", 1'b1);
    mem_req = 1'b1; mem_addr = 32'h10; mem_write_en = 1'b1; mem_data_in = 32'hFFFF_FFFF;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("halt_ready_%0d", k), {31'd0, mem_ready}, 32'd0);
      @(negedge clk);
    end
    mem_req = 1'b0;
    halted  = 1'b0;
    do_access(32'h10, 1'b0, 32'h0, "rd10_after_halt", 1'b0);

    // Reset during BUSY of a write: dropped, no done
    do_access(32'h20, 1'b1, 32'h0BAD_F00D, "wr20_old", 1'b0);
    @(negedge clk);
    mem_req = 1'b1; mem_addr = 32'h20; mem_write_en = 1'b1; mem_data_in = 32'h5566_7788;
    cnt = 0;
    while (!mem_ready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    mem_req = 1'b0;
    check("busy_ready", {31'd0, mem_ready}, 32'd0);
    rst_b = 1'b0;
    #1;
    check("midrst_ready", {31'd0, mem_ready}, 32'd1);
    check("midrst_data",  mem_data_out,       32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    do_access(32'h20, 1'b0, 32'h0, "rd20_after_rst", 1'b0);

    // Handshake stress on the LATENCY=1 instance
    @(negedge clk);
    s_req = 1'b1; s_addr = 32'h40; s_we = 1'b1; s_data_in = 32'hCAFE_F00D;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("stress_ready_%0d", k), {31'd0, s_ready}, {31'd0, (k % 3) == 0});
      if (s_done) cnt++;
      @(negedge clk);
    end
    s_req = 1'b0;
    check("stress_done_count", cnt, 32'd6);
    $display("txn stress: %0d done pulses in 20 cycles", cnt);
    repeat (4) @(negedge clk);

    // Randomized traffic against the model
    pool[0] = 32'hFFFC;
    pool[1] = 32'h0;
    for (int i = 2; i < 12; i++) pool[i] = $urandom_range(0, MEM_BYTES / 4 - 1) * 4;
    for (int i = 2; i < 12; i++) do_access(pool[i], 1'b1, $urandom, $sformatf("init%0d", i), 1'b0);
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      a    = pool[$urandom_range(0, 11)];
      if (kind <= 4)      do_access(a, 1'b0, 32'h0, $sformatf("rnd%0d_rd", t), 1'b0);
      else if (kind <= 7) do_access(a, 1'b1, $urandom, $sformatf("rnd%0d_wr", t), 1'b0);
      else if (kind == 8) do_access(a + $urandom_range(1, 3), 1'b0, 32'h0, $sformatf("rnd%0d_mis", t), 1'b0);
      else begin
        a = ($urandom_range(0, 1) == 0) ? (32'h0001_0000 + $urandom_range(0, 1000) * 4) : 32'hFFFF_FFFC;
        do_access(a, 1'($urandom_range(0, 1)), $urandom, $sformatf("rnd%0d_oor", t), 1'b0);
      end
    end
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
